// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and RCON helper for the AES-128 key schedule
package aes_pkg;
  typedef logic [127:0] aes_key_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} ks_state_e;
  localparam int AES128_ROUNDS = 10;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_rk_regfile.sv
// aes_rk_regfile: round-key storage, one write port and one combinational read port
//  clk_i, rst_ni        clock, async active-low reset (clears all entries)
//  we_i/waddr_i/wdata_i write strobe, entry index, round key
//  raddr_i/rdata_o      read index, round key (0 when index is out of range)
module aes_rk_regfile
  import aes_pkg::*;
#(
  parameter int DEPTH = AES128_ROUNDS + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [3:0]   waddr_i,
  input  logic [127:0] wdata_i,
  input  logic [3:0]   raddr_i,
  output logic [127:0] rdata_o
);
  aes_key_t rk [DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rk <= '{default: '0};
    else if (we_i && waddr_i < 4'(DEPTH)) rk[waddr_i] <= wdata_i;
  assign rdata_o = raddr_i < 4'(DEPTH) ? rk[raddr_i] : '0;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences an external single-round key-expansion datapath and stores round keys
//  key_valid_i/key_ready_o/key_i  host key load (accepted in IDLE or DONE)
//  flush_i                        abort expansion and invalidate the key set
//  rnd_start_o/rnd_key_o/rnd_rcon_o  round request to the datapath
//  rnd_key_i/rnd_valid_i          datapath result
//  rk_idx_i/rk_o                  round-key read port for the cipher core
//  keys_valid_o/busy_o/err_o      status; err_o is a sticky datapath timeout
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int TIMEOUT    = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_i,
  input  logic         flush_i,
  output logic         rnd_start_o,
  output logic [127:0] rnd_key_o,
  output logic [7:0]   rnd_rcon_o,
  input  logic [127:0] rnd_key_i,
  input  logic         rnd_valid_i,
  input  logic [3:0]   rk_idx_i,
  output logic [127:0] rk_o,
  output logic         keys_valid_o,
  output logic         busy_o,
  output logic         err_o
);
  localparam int TW = $clog2(TIMEOUT);
  ks_state_e      state, state_nx;
  logic [3:0]     round;
  logic [7:0]     rcon;
  logic [TW-1:0]  timer;
  aes_key_t       prev_key;
  logic           accept, rnd_done, last, timeout;
  assign accept   = key_valid_i && key_ready_o;
  assign rnd_done = state == WAIT && rnd_valid_i;
  assign last     = round == 4'(NUM_ROUNDS);
  assign timeout  = state == WAIT && !rnd_valid_i && timer == TW'(TIMEOUT - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (flush_i) state_nx = IDLE;
    else if (accept) state_nx = ISSUE;
    else if (state == ISSUE) state_nx = WAIT;
    else if (rnd_done) state_nx = last ? DONE : ISSUE;
    else if (timeout) state_nx = IDLE;
  end
  // datapath-facing outputs are zeroed outside an expansion so idle outputs read 0
  always_comb begin
    key_ready_o  = state == IDLE || state == DONE;
    busy_o       = state == ISSUE || state == WAIT;
    rnd_start_o  = state == ISSUE;
    keys_valid_o = state == DONE;
    rnd_key_o    = (state == ISSUE || state == WAIT) ? prev_key : '0;
    rnd_rcon_o   = (state == ISSUE || state == WAIT) ? rcon : '0;
  end
  // prev_key mirrors rk[round-1] so the datapath input needs no second read port
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      round    <= '0;
      rcon     <= 8'h01;
      timer    <= '0;
      prev_key <= '0;
      err_o    <= 1'b0;
    end else if (flush_i) err_o <= 1'b0;
    else if (accept) begin
      round    <= 4'd1;
      rcon     <= 8'h01;
      prev_key <= key_i;
      err_o    <= 1'b0;
    end else if (state == ISSUE) timer <= '0;
    else if (rnd_done && !last) begin
      round    <= round + 4'd1;
      rcon     <= xtime(rcon);
      prev_key <= rnd_key_i;
    end else if (timeout) err_o <= 1'b1;
    else if (state == WAIT) timer <= timer + 1'b1;
  aes_rk_regfile #(.DEPTH(NUM_ROUNDS + 1)) u_rf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (!flush_i && (accept || rnd_done)),
    .waddr_i (accept ? 4'd0 : round),
    .wdata_i (accept ? key_i : rnd_key_i),
    .raddr_i (rk_idx_i),
    .rdata_o (rk_o)
  );
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed bench with a behavioural single-round key-expansion datapath
module tb_aes_key_sched_ctrl;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic clk_i = 1'b0, rst_ni = 1'b0, key_valid_i = 1'b0, flush_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [3:0] rk_idx_i = '0;
  logic key_ready_o, rnd_start_o, rnd_valid_i, keys_valid_o, busy_o, err_o;
  logic [127:0] rnd_key_o, rnd_key_i, rk_o;
  logic [7:0] rnd_rcon_o;
  int tests = 0, fails = 0;
  int dp_lat = 1, stall_at = -1, starts = 0, dcnt = 0;
  logic [127:0] cap_key = '0;
  logic [7:0] cap_rc = '0;
  logic [7:0] rc_log [0:255];
  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
    .key_i(key_i), .flush_i(flush_i), .rnd_start_o(rnd_start_o), .rnd_key_o(rnd_key_o),
    .rnd_rcon_o(rnd_rcon_o), .rnd_key_i(rnd_key_i), .rnd_valid_i(rnd_valid_i),
    .rk_idx_i(rk_idx_i), .rk_o(rk_o), .keys_valid_o(keys_valid_o), .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] r, p;
    r = 8'h01;
    p = v;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] ks_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  function automatic logic [127:0] expand(input logic [127:0] k, input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i <= n; i++) begin
      k = ks_round(k, rc);
      rc = xt(rc);
    end
    return k;
  endfunction
  // datapath model: result valid dp_lat cycles after the start strobe, or never for round stall_at
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) dcnt <= 0;
    else if (rnd_start_o) begin
      starts <= starts + 1;
      cap_key <= rnd_key_o;
      cap_rc <= rnd_rcon_o;
      rc_log[8'(starts + 1)] <= rnd_rcon_o;
      dcnt <= (starts + 1 == stall_at) ? 0 : dp_lat;
    end else if (dcnt != 0) dcnt <= dcnt - 1;
  assign rnd_valid_i = dcnt == 1;
  assign rnd_key_i = ks_round(cap_key, cap_rc);
  task automatic load_key(input logic [127:0] k);
    @(negedge clk_i);
    key_i = k;
    key_valid_i = 1'b1;
    @(negedge clk_i);
    key_valid_i = 1'b0;
  endtask
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!keys_valid_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
  endtask
  task automatic wait_start(input int k, output bit ok);
    int n;
    n = 0;
    while (!(rnd_start_o && starts == k) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    ok = n < 300;
  endtask
  task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
    rk_idx_i = idx;
    #1;
    v = rk_o;
  endtask
  task automatic test_reset;
    logic [127:0] v;
    #2;
    tests++; if (key_ready_o !== 1'b1) begin fails++; $display("FAIL reset key_ready_o got %b exp 1", key_ready_o); end
    tests++; if ({busy_o, keys_valid_o, err_o, rnd_start_o} !== 4'b0) begin fails++; $display("FAIL reset status got %b exp 0000", {busy_o, keys_valid_o, err_o, rnd_start_o}); end
    tests++; if (rnd_rcon_o !== 8'h00 || rnd_key_o !== '0) begin fails++; $display("FAIL reset rnd outputs got %h/%h exp 0", rnd_rcon_o, rnd_key_o); end
    read_rk(4'd0, v);
    tests++; if (v !== '0) begin fails++; $display("FAIL reset rk0 got %h exp 0", v); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask
  task automatic test_fips_lat1;
    int n;
    logic [127:0] v;
    dp_lat = 1;
    load_key(FIPS_KEY);
    wait_done(100, n);
    tests++; if (n !== 20) begin fails++; $display("FAIL lat1 cycles got %0d exp 20", n); end
    tests++; if (keys_valid_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL lat1 keys_valid/busy got %b%b exp 10", keys_valid_o, busy_o); end
    read_rk(4'd1, v);
    tests++; if (v !== FIPS_RK1) begin fails++; $display("FAIL lat1 rk1 got %h exp %h", v, FIPS_RK1); end
    read_rk(4'd10, v);
    tests++; if (v !== FIPS_RK10) begin fails++; $display("FAIL lat1 rk10 got %h exp %h", v, FIPS_RK10); end
    read_rk(4'd0, v);
    tests++; if (v !== FIPS_KEY) begin fails++; $display("FAIL lat1 rk0 got %h exp %h", v, FIPS_KEY); end
    for (int i = 2; i < 10; i++) begin
      read_rk(4'(i), v);
      tests++; if (v !== expand(FIPS_KEY, i)) begin fails++; $display("FAIL lat1 rk%0d got %h exp %h", i, v, expand(FIPS_KEY, i)); end
    end
    read_rk(4'd11, v);
    tests++; if (v !== '0) begin fails++; $display("FAIL rk idx11 got %h exp 0", v); end
    read_rk(4'd15, v);
    tests++; if (v !== '0) begin fails++; $display("FAIL rk idx15 got %h exp 0", v); end
  endtask
  task automatic test_lat5;
    int n, base;
    logic [127:0] v;
    logic [7:0] exp_rc [10];
    exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    dp_lat = 5;
    base = starts;
    load_key(FIPS_KEY);
    wait_done(200, n);
    tests++; if (n !== 60) begin fails++; $display("FAIL lat5 cycles got %0d exp 60", n); end
    tests++; if (starts - base !== 10) begin fails++; $display("FAIL lat5 start pulses got %0d exp 10", starts - base); end
    for (int i = 0; i < 10; i++) begin
      tests++; if (rc_log[8'(base + i + 1)] !== exp_rc[i]) begin fails++; $display("FAIL lat5 rcon round %0d got %h exp %h", i + 1, rc_log[8'(base + i + 1)], exp_rc[i]); end
    end
    read_rk(4'd1, v);
    tests++; if (v !== FIPS_RK1) begin fails++; $display("FAIL lat5 rk1 got %h exp %h", v, FIPS_RK1); end
    read_rk(4'd10, v);
    tests++; if (v !== FIPS_RK10) begin fails++; $display("FAIL lat5 rk10 got %h exp %h", v, FIPS_RK10); end
  endtask
  task automatic test_timeout;
    int n, base;
    bit ok;
    logic [127:0] v;
    dp_lat = 1;
    base = starts;
    stall_at = base + 3;
    load_key(FIPS_KEY);
    wait_start(base + 2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL timeout round3 start got none exp pulse"); end
    n = 0;
    while (!err_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    tests++; if (n !== 17) begin fails++; $display("FAIL timeout cycles got %0d exp 17", n); end
    tests++; if ({err_o, key_ready_o, busy_o, keys_valid_o} !== 4'b1100) begin fails++; $display("FAIL timeout status got %b exp 1100", {err_o, key_ready_o, busy_o, keys_valid_o}); end
    stall_at = -1;
    load_key('0);
    tests++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL timeout err clear got err=%b busy=%b exp 0 1", err_o, busy_o); end
    wait_done(100, n);
    read_rk(4'd10, v);
    tests++; if (v !== ZERO_RK10) begin fails++; $display("FAIL zero key rk10 got %h exp %h", v, ZERO_RK10); end
  endtask
  task automatic test_flush;
    int base;
    bit ok;
    logic [127:0] v;
    dp_lat = 1;
    base = starts;
    load_key(FIPS_KEY);
    wait_start(base + 5, ok);
    tests++; if (!ok) begin fails++; $display("FAIL flush round6 start got none exp pulse"); end
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    tests++; if ({busy_o, key_ready_o, keys_valid_o, err_o} !== 4'b0100) begin fails++; $display("FAIL flush status got %b exp 0100", {busy_o, key_ready_o, keys_valid_o, err_o}); end
    read_rk(4'd6, v);
    tests++; if (v !== expand('0, 6)) begin fails++; $display("FAIL flush rk6 written got %h exp %h", v, expand('0, 6)); end
    read_rk(4'd5, v);
    tests++; if (v !== expand(FIPS_KEY, 5)) begin fails++; $display("FAIL flush rk5 got %h exp %h", v, expand(FIPS_KEY, 5)); end
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b0 || rnd_start_o !== 1'b0) begin fails++; $display("FAIL flush restart got busy=%b start=%b exp 0 0", busy_o, rnd_start_o); end
    key_i = FIPS_KEY;
    key_valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk_i);
    key_valid_i = 1'b0;
    flush_i = 1'b0;
    tests++; if (busy_o !== 1'b0 || key_ready_o !== 1'b1) begin fails++; $display("FAIL flush+key got busy=%b ready=%b exp 0 1", busy_o, key_ready_o); end
  endtask
  task automatic test_rekey;
    int n, bad;
    logic [127:0] v;
    dp_lat = 1;
    load_key(FIPS_KEY);
    key_i = '0;
    key_valid_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (key_ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
      @(negedge clk_i);
    end
    key_valid_i = 1'b0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL busy key_ready high cycles got %0d exp 0", bad); end
    wait_done(100, n);
    read_rk(4'd10, v);
    tests++; if (v !== FIPS_RK10) begin fails++; $display("FAIL held key rk10 got %h exp %h", v, FIPS_RK10); end
    load_key('0);
    tests++; if (keys_valid_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL rekey drop got kv=%b busy=%b exp 0 1", keys_valid_o, busy_o); end
    wait_done(100, n);
    tests++; if (n !== 20 || keys_valid_o !== 1'b1) begin fails++; $display("FAIL rekey done got n=%0d kv=%b exp 20 1", n, keys_valid_o); end
    read_rk(4'd10, v);
    tests++; if (v !== ZERO_RK10) begin fails++; $display("FAIL rekey rk10 got %h exp %h", v, ZERO_RK10); end
  endtask
  task automatic test_async_reset;
    int base;
    bit ok;
    logic [127:0] v;
    dp_lat = 1;
    base = starts;
    load_key(FIPS_KEY);
    wait_start(base + 3, ok);
    tests++; if (!ok) begin fails++; $display("FAIL areset round4 start got none exp pulse"); end
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    tests++; if ({busy_o, key_ready_o, keys_valid_o, err_o, rnd_start_o} !== 5'b01000) begin fails++; $display("FAIL areset status got %b exp 01000", {busy_o, key_ready_o, keys_valid_o, err_o, rnd_start_o}); end
    tests++; if (rnd_key_o !== '0 || rnd_rcon_o !== 8'h00) begin fails++; $display("FAIL areset rnd outputs got %h/%h exp 0", rnd_key_o, rnd_rcon_o); end
    read_rk(4'd0, v);
    tests++; if (v !== '0) begin fails++; $display("FAIL areset rk0 got %h exp 0", v); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++; if (busy_o !== 1'b0 || key_ready_o !== 1'b1) begin fails++; $display("FAIL post-reset got busy=%b ready=%b exp 0 1", busy_o, key_ready_o); end
  endtask
  initial begin
    test_reset;
    test_fips_lat1;
    test_lat5;
    test_timeout;
    test_flush;
    test_rekey;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish within 200000");
    $fatal(1, "watchdog");
  end
endmodule
